// File: rtl/sd_pkg.sv
// Shared constants and types for the SD sector feeder and its RAM.
package sd_pkg;
  localparam int SECTOR_WORDS = 256;
  localparam logic [7:0] CMD24 = 8'h58;
  localparam logic [7:0] DATA_TOKEN = 8'hFE;

  typedef enum logic [1:0] {IDLE, START, XFER} drain_state_t;
endpackage

// File: rtl/sd_sector_feeder_if.sv
// Producer stream and SD block-writer handshake bundled for the sector feeder.
interface sd_sector_feeder_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        flush;
  logic        write_start;
  logic [31:0] write_addr;
  logic [15:0] write_data;
  logic        write_busy;
  logic        write_request;
  logic [31:0] sectors_written;

  modport master (
    input  in_valid, in_data, flush, write_busy, write_request,
    output in_ready, write_start, write_addr, write_data, sectors_written
  );

  modport slave (
    output in_valid, in_data, flush, write_busy, write_request,
    input  in_ready, write_start, write_addr, write_data, sectors_written
  );
endinterface

// File: rtl/sd_pingpong_ram.sv
// Two-bank sector store: one write port, one registered read port whose
// output register drives the writer's data directly.
module sd_pingpong_ram #(
  parameter int WORDS = 256,
  localparam int AW = $clog2(2 * WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);
  logic [15:0] mem [0:2*WORDS-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sd_sector_feeder.sv
// Ping-pong sector buffer: packs a 16-bit word stream into sectors and
// hands each full sector to the SD single-block writer.
module sd_sector_feeder
  import sd_pkg::*;
#(
  parameter int          SECTOR_WORDS = sd_pkg::SECTOR_WORDS,
  parameter logic [31:0] START_SECTOR = 32'd0,
  parameter logic [15:0] PAD_WORD     = 16'hFFFF
) (
  input logic                 clk,
  input logic                 reset,
  sd_sector_feeder_if.master  bus
);
  localparam int CW = $clog2(SECTOR_WORDS) + 1;
  localparam int AW = $clog2(2 * SECTOR_WORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(SECTOR_WORDS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(SECTOR_WORDS);

  logic [1:0]    full_reg;
  logic          fb_reg;
  logic          db_reg;
  logic [CW-1:0] wcnt_reg;
  logic [CW-1:0] rcnt_reg;
  logic          padding_reg;
  logic [31:0]   addr_reg;
  logic [31:0]   count_reg;
  drain_state_t  state_reg, state_next;

  logic          ready;
  logic          accept;
  logic          wr_en;
  logic          wr_last;
  logic [15:0]   wr_data;
  logic          rd_en;
  logic          latch;
  logic          done;
  logic          start;
  logic [1:0]    set_mask;
  logic [1:0]    clr_mask;
  logic [15:0]   rd_data;

  // Fill side: padding words take the write port exactly like producer words.
  assign ready   = !full_reg[fb_reg] && !padding_reg;
  assign accept  = bus.in_valid && ready;
  assign wr_en   = accept || padding_reg;
  assign wr_data = padding_reg ? PAD_WORD : bus.in_data;
  assign wr_last = wr_en && (wcnt_reg == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      fb_reg      <= 1'b0;
      wcnt_reg    <= '0;
      padding_reg <= 1'b0;
    end else begin
      if (wr_en) begin
        if (wr_last) begin
          fb_reg      <= ~fb_reg;
          wcnt_reg    <= '0;
          padding_reg <= 1'b0;
        end else begin
          wcnt_reg <= wcnt_reg + 1'b1;
        end
      end
      // A coincident word lands first; padding only if the sector is still open.
      if (bus.flush && !padding_reg && !wr_last && (accept || wcnt_reg != '0))
        padding_reg <= 1'b1;
    end
  end

  assign set_mask = wr_last ? (2'b01 << fb_reg) : 2'b00;
  assign clr_mask = done ? (2'b01 << db_reg) : 2'b00;

  always_ff @(posedge clk) begin
    if (reset) full_reg <= 2'b00;
    else full_reg <= (full_reg | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    rd_en      = 1'b0;
    latch      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (full_reg[db_reg]) begin
          latch      = 1'b1;
          state_next = START;
        end
      end
      START: begin
        start = 1'b1;
        if (bus.write_busy) state_next = XFER;
      end
      XFER: begin
        // The writer's final request per block has no word behind it.
        if (bus.write_request && rcnt_reg < FULL_CNT) rd_en = 1'b1;
        if (!bus.write_busy) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_reg    <= 1'b0;
      rcnt_reg  <= '0;
      addr_reg  <= START_SECTOR;
      count_reg <= '0;
    end else begin
      if (latch) begin
        addr_reg <= START_SECTOR + count_reg;
        rcnt_reg <= '0;
      end
      if (rd_en) rcnt_reg <= rcnt_reg + 1'b1;
      if (done) begin
        db_reg    <= ~db_reg;
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  sd_pingpong_ram #(.WORDS(SECTOR_WORDS)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .waddr ({fb_reg, wcnt_reg[CW-2:0]}),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr ({db_reg, rcnt_reg[CW-2:0]}),
    .rdata (rd_data)
  );

  assign bus.in_ready        = ready;
  assign bus.write_start     = start;
  assign bus.write_addr      = addr_reg;
  assign bus.write_data      = rd_data;
  assign bus.sectors_written = count_reg;
endmodule

// File: doc/sd_sector_feeder.md
# sd_sector_feeder

Ping-pong sector buffer directly upstream of the SD single-block writer. Accepts a 16-bit word stream from a producer, packs it into 256-word (512-byte) sectors across two banks, then launches one CMD24 write per full sector. It supplies `write_data` on each `write_request` pulse and advances the sector address after every completed block. Producers can keep streaming into one bank while the other bank drains to the card.

## Interface
Parameters:
- `SECTOR_WORDS`, 256: words per sector. Must match the writer's block length.
- `START_SECTOR`, 32'd0: block address of the first sector written after reset.
- `PAD_WORD`, 16'hFFFF: fill value used when `flush` closes a partial sector.

Ports:
- `clk`  in  1: single clock. Shared with the writer.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: producer word valid.
- `in_data`  in  16: producer word.
- `in_ready`  out  1: word accepted on a cycle where `in_valid && in_ready`.
- `flush`  in  1: one-cycle pulse that closes the current partial sector.
- `write_start`  out  1: level request to the writer. The writer edge-detects it.
- `write_addr`  out  32: sector address for CMD24.
- `write_data`  out  16: current word for the writer.
- `write_busy`  in  1: writer busy.
- `write_request`  in  1: writer next-word pulse.
- `sectors_written`  out  32: count of completed block writes.

## Operation
- Two banks, `full[1:0]`, fill pointer `fb`, drain pointer `db`, fill count `wcnt[8:0]`, read count `rcnt[8:0]`.
- **Fill side:**
  - `in_ready = !full[fb] && !padding`.
  - Each accepted word is written to `bank[fb][wcnt]` and `wcnt` increments.
  - When `wcnt` reaches `SECTOR_WORDS-1` and that word is accepted: set `full[fb]`, toggle `fb`, clear `wcnt`.
- **Flush:**
  - With `wcnt>0`, enter `padding`: write `PAD_WORD` one word per cycle until the bank is full, then close it as above.
  - With `wcnt==0`, flush is a no-op; no empty sector is ever written.
  - `flush` coincident with an accepted word: the word is stored first, then padding starts.
- **Drain FSM states:**
  - IDLE: when `full[db]`, latch `write_addr = START_SECTOR + sectors_written`, clear `rcnt`, go to START.
  - START: hold `write_start=1` until `write_busy=1` is sampled, then drop `write_start` and go to XFER.
  - XFER:
    - On `write_request` with `rcnt < SECTOR_WORDS`: read `bank[db][rcnt]` and increment `rcnt`.
    - Requests with `rcnt == SECTOR_WORDS` are ignored. The writer issues 257 requests per block; the last one is extraneous.
    - When `write_busy` falls: clear `full[db]`, toggle `db`, increment `sectors_written`, go to IDLE.
- `write_addr` is held stable from IDLE→START until the next latch.
- A fill-side full-set and a drain-side full-clear of different banks in the same cycle both take effect.

## Timing
- **Reset values:** `in_ready=1`, `write_start=0`, `write_addr=START_SECTOR`, `write_data=0`, `sectors_written=0`, FSM=IDLE, `full=0`, `fb=db=0`.
- **Reset mid-transfer:** all of the above state is restored immediately. The partial sector is discarded.
- **Read latency:** `write_request` high at cycle n → `write_data` presents the next word at n+1 and holds until the next accepted request. The writer samples it at n+2.
- **First request:** the first request (during the 8'hFE header) yields word 0.
- **START→IDLE latency:** IDLE→START takes 1 cycle after `full[db]` is seen. `write_start` stays high for at least the 2 cycles the writer's synchronizer needs, since `write_busy` cannot rise earlier.
- **Fill throughput:** 1 word/cycle sustained while a bank is free.
- **Stall point:** `in_ready` falls the cycle after the 256th word when the other bank is still full.

## Structure
- Package `sd_pkg`:
  - `SECTOR_WORDS`
  - `CMD24 = 8'h58`
  - `DATA_TOKEN = 8'hFE`
  - drain-state enum `{IDLE, START, XFER}`
- Sub-module `sd_pingpong_ram`:
  - 2×`SECTOR_WORDS`×16.
  - One write port.
  - One registered read port with read-enable; its output register is `write_data`.

## Test plan
- **Single full sector:** stream 256 words `16'h0000..16'h00FF` with a behavioural writer model. Expect one `write_start` with `write_addr=0`, 257 requests, words 0..255 received in order, and `sectors_written=1`.
- **Back-to-back sectors:** stream 768 words continuously. Expect `in_ready` low only while both banks are full, addresses 0,1,2, and no data loss or reorder.
- **Flush partial:** 10 words then `flush`. Expect 246 `16'hFFFF` pad words after them, and the block issued. A second `flush` with `wcnt==0` issues no write.
- **Coincident flush:** `flush` in the same cycle as word 5 accepted. Expect word 5 stored at index 5 and padding from index 6.
- **Extra request:** the 257th `write_request` leaves `write_data` and `rcnt` unchanged.
- **Reset during XFER** (after 100 requests): expect `write_start=0`, `sectors_written=0`, `in_ready=1`. The next sector starts again at `START_SECTOR`.
